// File: rtl/mb_seq_multiplier.sv
// Iterative 32x32 signed radix-4 Modified Booth multiplier; one Booth digit is added per RUN cycle.
// Build option: define MB_SEQ_EARLY_TERM_EN to stop once every remaining multiplier digit is zero.

module pp_mb_generator (
   input  logic [31:0] a,
   input  logic        one_j,
   input  logic        two_j,
   input  logic        sign_j,
   output logic [32:0] pp
);
   logic [32:0] mag;
   logic [32:0] row;

   // Ones'-complement row; the MSB leaves inverted for sign-extension-free PP arrays.
   always_comb begin
      mag = '0;
      if (one_j)
         mag = {a[31], a};
      else if (two_j)
         mag = {a, 1'b0};
      row = mag ^ {33{sign_j}};
      pp  = {~row[32], row[31:0]};
   end
endmodule

module mb_seq_multiplier (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] product,
   output logic        busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } mul_req_t;

   state_t      state, state_nxt;
   mul_req_t    op_q;
   logic [63:0] acc;
   logic [3:0]  j;

   logic        accept;
   logic        last_digit;
   logic [32:0] b_ext;
   logic [2:0]  trip;
   logic        one, two, sign;
   logic [32:0] pp;
   logic [32:0] row_true;
   logic [63:0] row_ext;
   logic [63:0] row_sh;

   assign accept = (state == IDLE) && in_valid;

   // b_ext[0] is the implicit b[-1] = 0, so digit j's triplet starts at bit 2j.
   assign b_ext = {op_q.b, 1'b0};
   assign trip  = b_ext[{j, 1'b0} +: 3];
   assign one   = trip[1] ^ trip[0];
   assign two   = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
   assign sign  = trip[2];

   pp_mb_generator u_ppgen (
      .a      (op_q.a),
      .one_j  (one),
      .two_j  (two),
      .sign_j (sign),
      .pp     (pp)
   );

   // Undo the inverted MSB, sign-extend, then +sign turns ones' into two's complement.
   assign row_true = {~pp[32], pp[31:0]};
   assign row_ext  = {{31{row_true[32]}}, row_true} + {63'd0, sign};
   assign row_sh   = row_ext << {j, 1'b0};

`ifdef MB_SEQ_EARLY_TERM_EN
   // Once b[31:2j+1] is pure sign, every higher triplet is 000 or 111 and adds nothing.
   logic [31:0] b_hi;
   assign b_hi       = 32'($signed(op_q.b) >>> ({1'b0, j, 1'b0} + 6'd1));
   assign last_digit = (j == 4'd15) || (b_hi == '0) || (b_hi == '1);
`else
   assign last_digit = (j == 4'd15);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN:     if (last_digit) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= '0;
         acc  <= '0;
         j    <= '0;
      end else if (accept) begin
         op_q <= '{a: a, b: b};
         acc  <= '0;
         j    <= '0;
      end else if (state == RUN) begin
         acc <= acc + row_sh;
         j   <= j + 4'd1;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign product   = acc;
endmodule

// File: tb/tb_mb_seq_multiplier.sv
// Self-checking bench for mb_seq_multiplier: directed vector table, backpressure/reset sequences, random scoreboard run.
// Expected latencies follow MB_SEQ_EARLY_TERM_EN when the bench is built with it.

module tb_mb_seq_multiplier;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;
   logic [63:0] sb[$];

   always #5 clk = ~clk;

   mb_seq_multiplier dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] p;
      int          lat_et;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] xs;
      logic signed [63:0] ys;
      xs = $signed(x);
      ys = $signed(y);
      return xs * ys;
   endfunction

   function automatic int exp_lat(input int lat_et);
`ifdef MB_SEQ_EARLY_TERM_EN
      return lat_et;
`else
      return (lat_et > 0) ? 16 : 16;
`endif
   endfunction

   task automatic pop_check(input string name);
      logic [63:0] exp;
      if (sb.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: result with empty scoreboard, got %h", name, product);
      end else begin
         exp = sb.pop_front();
         check(name, product, exp);
      end
   endtask

   // One operation with out_ready held high; checks latency, product and return to IDLE.
   task automatic run_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                          input logic [63:0] vp, input int lat);
      int cyc;
      @(negedge clk);
      check({name, "_in_ready"}, 64'(in_ready), 64'd1);
      a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
      sb.push_back(vp);
      @(negedge clk);
      in_valid = 1'b0; a = $urandom; b = $urandom;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_latency"}, 64'(cyc), 64'(lat));
      pop_check({name, "_product"});
      @(negedge clk);
      check({name, "_idle_after"}, {62'd0, in_ready, out_valid}, 64'd2);
   endtask

   task automatic wait_out_valid(input string name);
      int cyc;
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check({name, "_out_valid"}, 64'(out_valid), 64'd1);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] bp_exp;
      logic        busy_seen;
      int          sent, recv, cyc;
      logic        have;
      logic [31:0] ra, rb;

      vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 2};
      vecs[1] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 16};
      vecs[2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 16};
      vecs[3] = '{32'h1234_5678, 32'h0000_0000, 64'h0000_0000_0000_0000, 1};
      vecs[4] = '{32'h1234_5678, 32'hFFFF_FFFF, 64'hFFFF_FFFF_EDCB_A988, 1};
      vecs[5] = '{32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000, 2};
      vecs[6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 16};
      vecs[7] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 16};
      vecs[8] = '{32'hFFFF_FFF9, 32'h0000_0009, 64'hFFFF_FFFF_FFFF_FFC1, 3};
      vecs[9] = '{32'hFFFF_FFFF, 32'h8000_0000, 64'h0000_0000_8000_0000, 16};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #12;
      check("reset_product", product, 64'd0);
      check("reset_flags", {60'd0, in_ready, out_valid, busy, 1'b0}, 64'h8);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p, exp_lat(vecs[i].lat_et));

      // Backpressure: result held, in_valid pulse while busy is ignored.
      @(negedge clk);
      a = 32'h0001_2345; b = 32'hFFFF_FF9D; in_valid = 1'b1; out_ready = 1'b0;
      bp_exp = ref_mul(a, b);
      @(negedge clk);
      in_valid = 1'b0;
      wait_out_valid("bp");
      for (int i = 0; i < 10; i++) begin
         check($sformatf("bp_hold%0d", i), {product, 3'b0} >> 3, bp_exp);
         check($sformatf("bp_flags%0d", i), {61'd0, in_ready, out_valid, busy}, 64'd3);
         @(negedge clk);
         in_valid = (i == 4);
         a = 32'h0000_0007; b = 32'h0000_0003;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {61'd0, in_ready, out_valid, busy}, 64'd4);
      check("bp_product_kept", product, bp_exp);
      busy_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy || out_valid) busy_seen = 1'b1;
      end
      check("bp_pulse_ignored", 64'(busy_seen), 64'd0);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) @(negedge clk);
      check("pre_reset_busy", 64'(busy), 64'd1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_product", product, 64'd0);
      check("async_reset_flags", {61'd0, in_ready, out_valid, busy}, 64'd4);
      @(negedge clk);
      rst = 1'b0;
      run_vec("post_reset", 32'hFFFF_FFF9, 32'h0000_0009, 64'hFFFF_FFFF_FFFF_FFC1, exp_lat(3));

      // Random traffic with gaps on both handshakes.
      sent = 0; recv = 0; cyc = 0; have = 1'b0; ra = '0; rb = '0;
      while (recv < 1500 && cyc < 60000) begin
         @(negedge clk);
         cyc++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (out_valid && out_ready) begin
            pop_check($sformatf("rand%0d", recv));
            recv++;
         end
         if (sent < 1500) begin
            if (!have) begin
               case ($urandom_range(0, 3))
                  0: begin ra = $urandom; rb = $urandom_range(0, 300) - 150; end
                  1: begin
                     ra = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                     rb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
                  end
                  default: begin ra = $urandom; rb = $urandom; end
               endcase
               have = 1'b1;
            end
            a = ra; b = rb;
            in_valid = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
               sb.push_back(ref_mul(ra, rb));
               sent++;
               have = 1'b0;
            end
         end else begin
            in_valid = 1'b0;
         end
      end
      check("rand_all_received", {32'(recv), 32'(sb.size())}, {32'd1500, 32'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
